// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter
// Write-back arbiter for a scalar register file with one write port.
// ALU results always win and are written one cycle after they arrive.
// Load results are buffered in an in-order FIFO that drains only in
// cycles with no ALU result. busyMask flags registers with buffered loads.
//
// Optional feature: define WB_BYPASS_EN to let a load skip the FIFO when
// the FIFO is empty and no ALU result is present. That load is written
// one cycle after acceptance instead of two.
module scalar_wb_arbiter #(
  parameter int registerSize     = 32,
  parameter int registerQuantity = 4,
  parameter int selectionBits    = 2,
  parameter int fifoDepth        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           aluValid,
  input  logic [selectionBits-1:0]       aluRd,
  input  logic [registerSize-1:0]        aluData,
  input  logic                           memValid,
  output logic                           memReady,
  input  logic [selectionBits-1:0]       memRd,
  input  logic [registerSize-1:0]        memData,
  output logic                           regWrEn,
  output logic [selectionBits-1:0]       regToWrite,
  output logic [registerSize-1:0]        dataIn,
  output logic [registerQuantity-1:0]    busyMask,
  output logic [$clog2(fifoDepth):0]     fifoCount
);

  localparam int PTR_W = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(fifoDepth);

  // Load buffer storage. The head must be visible in the cycle it is
  // selected, so the read is asynchronous (small distributed memory).
  logic [selectionBits-1:0] fifo_rd   [fifoDepth];
  logic [registerSize-1:0]  fifo_data [fifoDepth];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic                     wr_en_reg, wr_en_next;
  logic [selectionBits-1:0] wr_idx_reg, wr_idx_next;
  logic [registerSize-1:0]  wr_data_reg, wr_data_next;

  logic                     fifo_empty;
  logic                     accept;
  logic                     bypass;
  logic                     enq;
  logic                     deq;
  logic [selectionBits-1:0] head_rd;
  logic [registerSize-1:0]  head_data;

  assign fifo_empty = (count_reg == '0);

  // Ready depends only on occupancy (never on a same-cycle dequeue) and is
  // forced low while reset is asserted.
  assign memReady = reset & (count_reg < DEPTH_C);
  assign accept   = memValid & memReady;

  // The FIFO head is only written in cycles the ALU leaves the port free.
  assign deq = ~aluValid & ~fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = accept & fifo_empty & ~aluValid;
`else
  assign bypass = 1'b0;
`endif

  assign enq = accept & ~bypass;

  assign head_rd   = fifo_rd[rd_ptr_reg];
  assign head_data = fifo_data[rd_ptr_reg];

  // Next-state for pointers and occupancy; pointers wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (enq) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // FIFO storage write; contents are qualified by occupancy so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[wr_ptr_reg]   <= memRd;
      fifo_data[wr_ptr_reg] <= memData;
    end
  end

  // Write-port selection: ALU first, then FIFO head, then bypassed load.
  // Index and data hold their previous values when no write is issued.
  always_comb begin
    wr_en_next   = 1'b0;
    wr_idx_next  = wr_idx_reg;
    wr_data_next = wr_data_reg;
    if (aluValid) begin
      wr_en_next   = 1'b1;
      wr_idx_next  = aluRd;
      wr_data_next = aluData;
    end else if (deq) begin
      wr_en_next   = 1'b1;
      wr_idx_next  = head_rd;
      wr_data_next = head_data;
    end else if (bypass) begin
      wr_en_next   = 1'b1;
      wr_idx_next  = memRd;
      wr_data_next = memData;
    end
  end

  // Registered write port toward the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_reg   <= 1'b0;
      wr_idx_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg   <= wr_en_next;
      wr_idx_reg  <= wr_idx_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign regWrEn    = wr_en_reg;
  assign regToWrite = wr_idx_reg;
  assign dataIn     = wr_data_reg;
  assign fifoCount  = count_reg;

  // Per-register count of buffered loads; a busy bit stays set until the
  // last buffered load targeting that register has been popped.
  genvar gi;
  generate
    for (gi = 0; gi < registerQuantity; gi++) begin : g_busy
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             hit_enq;
      logic             hit_deq;

      assign hit_enq = enq & (memRd == selectionBits'(gi));
      assign hit_deq = deq & (head_rd == selectionBits'(gi));

      // Track entries added and removed for this register.
      always_comb begin
        cnt_next = cnt_reg;
        case ({hit_enq, hit_deq})
          2'b10:   cnt_next = cnt_reg + CNT_W'(1);
          2'b01:   cnt_next = cnt_reg - CNT_W'(1);
          default: cnt_next = cnt_reg;
        endcase
      end

      // Count register, cleared with the FIFO.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign busyMask[gi] = (cnt_reg != '0);
    end
  endgenerate

endmodule
